// File: rtl/snn_sched_pkg.sv
// Shared constants and helpers for the multi-channel AER event scheduler.
package snn_sched_pkg;

  localparam int   EVT_WIDTH_DEF = 12;
  localparam logic ARB_FIXED     = 1'b0;
  localparam logic ARB_RR        = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/sched_fifo.sv
// Per-channel event FIFO. Pointers carry one extra wrap bit so that full and
// empty are distinguishable without an occupancy counter.
module sched_fifo #(
  parameter int WIDTH      = 12,
  parameter int DEPTH      = 8,
  parameter int DEPTH_ADDR = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic             empty,
  output logic             full,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_ADDR:0] wr_ptr, rd_ptr;
  logic                do_push, do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[DEPTH_ADDR] != rd_ptr[DEPTH_ADDR]) &&
                    (wr_ptr[DEPTH_ADDR-1:0] == rd_ptr[DEPTH_ADDR-1:0]);
  // A push into a full FIFO is lost even if a pop frees a slot this cycle.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign data_out = mem[rd_ptr[DEPTH_ADDR-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_ADDR-1:0]] <= data_in;
  end

endmodule

// File: rtl/event_scheduler_mc.sv
// Multi-channel AER event scheduler: per-channel FIFOs arbitrated into one
// show-ahead output register. Optional overflow counters: SCHED_STATS_EN.
module event_scheduler_mc
  import snn_sched_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int EVT_WIDTH  = EVT_WIDTH_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3,
  parameter int CH_W       = (NUM_CH > 1) ? clog2(NUM_CH) : 1,
  parameter int CNT_W      = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH-1:0]           EVT_PUSH,
  input  logic [NUM_CH*EVT_WIDTH-1:0] EVT_DATA,
  output logic [NUM_CH-1:0]           SCHED_FULL,
  input  logic                        CTRL_SCHED_POP_N,
  output logic                        SCHED_EMPTY,
  output logic [EVT_WIDTH-1:0]        SCHED_DATA_OUT,
  output logic [CH_W-1:0]             SCHED_CH,
  input  logic                        SPI_OPEN_LOOP,
  input  logic                        SPI_ARB_RR
`ifdef SCHED_STATS_EN
  ,
  output logic [NUM_CH*CNT_W-1:0]     SCHED_OVF_CNT
`endif
);

  logic [1:0]                           open_sync, arb_sync;
  logic [NUM_CH-1:0]                    push_req, fifo_pop, fifo_empty, fifo_full;
  logic [NUM_CH-1:0][EVT_WIDTH-1:0]     fifo_dout;
  logic [CH_W-1:0]                      rr_ptr, grant;
  logic                                 grant_vld, pop, load, rr_mode;

  always_ff @(posedge CLK) begin
    if (RST) begin
      open_sync <= '0;
      arb_sync  <= '0;
    end else begin
      open_sync <= {open_sync[0], SPI_OPEN_LOOP};
      arb_sync  <= {arb_sync[0], SPI_ARB_RR};
    end
  end

  assign rr_mode = (arb_sync[1] == ARB_RR);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // ch0 carries loopback spikes, which are discarded during open-loop runs.
    assign push_req[i] = EVT_PUSH[i] && !((i == 0) && open_sync[1]);
    assign fifo_pop[i] = load && (grant == CH_W'(i));

    sched_fifo #(
      .WIDTH      (EVT_WIDTH),
      .DEPTH      (FIFO_DEPTH),
      .DEPTH_ADDR (FIFO_AW)
    ) u_fifo (
      .clk      (CLK),
      .rst      (RST),
      .push     (push_req[i]),
      .pop      (fifo_pop[i]),
      .data_in  (EVT_DATA[i*EVT_WIDTH +: EVT_WIDTH]),
      .empty    (fifo_empty[i]),
      .full     (fifo_full[i]),
      .data_out (fifo_dout[i])
    );
  end

  assign SCHED_FULL = fifo_full;

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    if (rr_mode) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!grant_vld && !fifo_empty[(int'(rr_ptr) + k) % NUM_CH]) begin
          grant     = CH_W'((int'(rr_ptr) + k) % NUM_CH);
          grant_vld = 1'b1;
        end
      end
    end else begin
      // Descending scan so the lowest non-empty index wins.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (!fifo_empty[k]) begin
          grant     = CH_W'(k);
          grant_vld = 1'b1;
        end
      end
    end
  end

  assign pop  = !CTRL_SCHED_POP_N && !SCHED_EMPTY;
  assign load = (SCHED_EMPTY || pop) && grant_vld;

  always_ff @(posedge CLK) begin
    if (RST) begin
      SCHED_EMPTY    <= 1'b1;
      SCHED_DATA_OUT <= '0;
      SCHED_CH       <= '0;
      rr_ptr         <= '0;
    end else if (load) begin
      SCHED_EMPTY    <= 1'b0;
      SCHED_DATA_OUT <= fifo_dout[grant];
      SCHED_CH       <= grant;
      rr_ptr         <= (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
    end else if (pop) begin
      SCHED_EMPTY    <= 1'b1;
    end
  end

`ifdef SCHED_STATS_EN
  logic [NUM_CH-1:0][CNT_W-1:0] ovf_cnt;

  // Open-loop discards never reach a FIFO, so they are not counted as drops.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (push_req[i] && fifo_full[i] && (ovf_cnt[i] != '1))
          ovf_cnt[i] <= ovf_cnt[i] + 1'b1;
    end
  end

  assign SCHED_OVF_CNT = ovf_cnt;
`endif

endmodule

// File: tb/tb_event_scheduler_mc.sv
// Directed bench for event_scheduler_mc: reset, latency, overflow, arbitration,
// open-loop discard and mid-run reset, with hand-computed expectations.
module tb_event_scheduler_mc;

  localparam int NUM_CH = 2;
  localparam int EW     = 12;
  localparam int CNT_W  = 16;

  logic               CLK = 1'b0;
  logic               RST;
  logic [NUM_CH-1:0]  EVT_PUSH;
  logic [NUM_CH*EW-1:0] EVT_DATA;
  logic [NUM_CH-1:0]  SCHED_FULL;
  logic               CTRL_SCHED_POP_N;
  logic               SCHED_EMPTY;
  logic [EW-1:0]      SCHED_DATA_OUT;
  logic [0:0]         SCHED_CH;
  logic               SPI_OPEN_LOOP;
  logic               SPI_ARB_RR;
`ifdef SCHED_STATS_EN
  logic [NUM_CH*CNT_W-1:0] SCHED_OVF_CNT;
`endif

  int total = 0;
  int bad   = 0;

  event_scheduler_mc #(.NUM_CH(NUM_CH), .EVT_WIDTH(EW)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .EVT_PUSH         (EVT_PUSH),
    .EVT_DATA         (EVT_DATA),
    .SCHED_FULL       (SCHED_FULL),
    .CTRL_SCHED_POP_N (CTRL_SCHED_POP_N),
    .SCHED_EMPTY      (SCHED_EMPTY),
    .SCHED_DATA_OUT   (SCHED_DATA_OUT),
    .SCHED_CH         (SCHED_CH),
    .SPI_OPEN_LOOP    (SPI_OPEN_LOOP),
    .SPI_ARB_RR       (SPI_ARB_RR)
`ifdef SCHED_STATS_EN
    ,
    .SCHED_OVF_CNT    (SCHED_OVF_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic push(input logic [1:0] mask, input logic [EW-1:0] d0, input logic [EW-1:0] d1);
    EVT_PUSH = mask;
    EVT_DATA = {d1, d0};
  endtask

  initial begin
    RST = 1'b1; EVT_PUSH = '0; EVT_DATA = '0; CTRL_SCHED_POP_N = 1'b1;
    SPI_OPEN_LOOP = 1'b0; SPI_ARB_RR = 1'b0;

    // Reset
    tick(); tick();
    chk("rst_empty", SCHED_EMPTY, 1);
    chk("rst_full",  SCHED_FULL, 0);
    chk("rst_data",  SCHED_DATA_OUT, 0);
    chk("rst_ch",    SCHED_CH, 0);
`ifdef SCHED_STATS_EN
    chk("rst_ovf", SCHED_OVF_CNT, 0);
`endif
    RST = 1'b0;
    tick();

    // Single push on ch1: output valid one edge after the push edge
    push(2'b10, 12'h000, 12'h3A5);
    tick();
    push(2'b00, 12'h000, 12'h000);
    chk("lat_empty_t", SCHED_EMPTY, 1);
    tick();
    chk("single_empty", SCHED_EMPTY, 0);
    chk("single_data",  SCHED_DATA_OUT, 12'h3A5);
    chk("single_ch",    SCHED_CH, 1);
    // Pop with nothing queued: empty again, data held
    CTRL_SCHED_POP_N = 1'b0;
    tick();
    CTRL_SCHED_POP_N = 1'b1;
    chk("drain_empty", SCHED_EMPTY, 1);
    chk("drain_hold",  SCHED_DATA_OUT, 12'h3A5);

    // Fill ch1: first word moves to output, FIFO holds 8 after the 9th push
    for (int n = 1; n <= 9; n++) begin
      push(2'b10, 12'h000, 12'(12'h100 + n));
      tick();
      if (n == 8) chk("full_after8", SCHED_FULL, 2'b00);
    end
    chk("full_after9", SCHED_FULL, 2'b10);
    chk("full_out",    SCHED_DATA_OUT, 12'h101);
    // Push to full while draining: push dropped, occupancy drops to 7
    push(2'b10, 12'h000, 12'h10A);
    CTRL_SCHED_POP_N = 1'b0;
    tick();
    push(2'b00, 12'h000, 12'h000);
    chk("ovf_full", SCHED_FULL, 2'b00);
    chk("ovf_out",  SCHED_DATA_OUT, 12'h102);
`ifdef SCHED_STATS_EN
    chk("ovf_cnt", SCHED_OVF_CNT, {16'd1, 16'd0});
`endif
    for (int k = 3; k <= 9; k++) begin
      tick();
      chk("ovf_drain", SCHED_DATA_OUT, 12'(12'h100 + k));
    end
    tick();
    CTRL_SCHED_POP_N = 1'b1;
    chk("ovf_empty", SCHED_EMPTY, 1);

    // Fixed-priority arbitration
    for (int k = 0; k < 3; k++) begin
      push(2'b11, 12'(12'hA00 + k), 12'(12'hB00 + k));
      tick();
    end
    push(2'b00, 12'h000, 12'h000);
    CTRL_SCHED_POP_N = 1'b0;
    for (int j = 0; j < 6; j++) begin
      chk("fix_ch",   SCHED_CH, (j < 3) ? 0 : 1);
      chk("fix_data", SCHED_DATA_OUT, (j < 3) ? 12'hA00 + j : 12'hB00 + j - 3);
      tick();
    end
    CTRL_SCHED_POP_N = 1'b1;
    chk("fix_empty", SCHED_EMPTY, 1);

    // Round-robin arbitration
    SPI_ARB_RR = 1'b1;
    tick(); tick(); tick();
    for (int k = 0; k < 3; k++) begin
      push(2'b11, 12'(12'hA00 + k), 12'(12'hB00 + k));
      tick();
    end
    push(2'b00, 12'h000, 12'h000);
    CTRL_SCHED_POP_N = 1'b0;
    for (int j = 0; j < 6; j++) begin
      chk("rr_ch",   SCHED_CH, j % 2);
      chk("rr_data", SCHED_DATA_OUT, ((j % 2) ? 12'hB00 : 12'hA00) + j / 2);
      tick();
    end
    CTRL_SCHED_POP_N = 1'b1;
    chk("rr_empty", SCHED_EMPTY, 1);

    // Open loop: ch0 discarded, ch1 delivered
    SPI_OPEN_LOOP = 1'b1;
    tick(); tick(); tick();
    push(2'b01, 12'h5C0, 12'h000);
    tick();
    push(2'b00, 12'h000, 12'h000);
    tick(); tick(); tick();
    chk("ol_ch0_empty", SCHED_EMPTY, 1);
    push(2'b10, 12'h000, 12'h5C1);
    tick();
    push(2'b00, 12'h000, 12'h000);
    tick();
    chk("ol_ch1_empty", SCHED_EMPTY, 0);
    chk("ol_ch1_data",  SCHED_DATA_OUT, 12'h5C1);
    chk("ol_ch1_ch",    SCHED_CH, 1);
    CTRL_SCHED_POP_N = 1'b0;
    tick();
    CTRL_SCHED_POP_N = 1'b1;
    chk("ol_pop_empty", SCHED_EMPTY, 1);
    SPI_OPEN_LOOP = 1'b0;
    tick(); tick(); tick();
    push(2'b01, 12'h5C2, 12'h000);
    tick();
    push(2'b00, 12'h000, 12'h000);
    tick();
    chk("cl_ch0_data", SCHED_DATA_OUT, 12'h5C2);
    chk("cl_ch0_ch",   SCHED_CH, 0);
    CTRL_SCHED_POP_N = 1'b0;
    tick();
    CTRL_SCHED_POP_N = 1'b1;

    // Mid-run reset discards queued words
    for (int k = 0; k < 4; k++) begin
      push(2'b10, 12'h000, 12'(12'h600 + k));
      tick();
    end
    push(2'b00, 12'h000, 12'h000);
    chk("mid_pre_empty", SCHED_EMPTY, 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mid_empty", SCHED_EMPTY, 1);
    chk("mid_full",  SCHED_FULL, 0);
    chk("mid_data",  SCHED_DATA_OUT, 0);
    chk("mid_ch",    SCHED_CH, 0);
`ifdef SCHED_STATS_EN
    chk("mid_ovf", SCHED_OVF_CNT, 0);
`endif
    CTRL_SCHED_POP_N = 1'b0;
    tick(); tick(); tick();
    CTRL_SCHED_POP_N = 1'b1;
    chk("mid_stale", SCHED_EMPTY, 1);
    chk("mid_stale_data", SCHED_DATA_OUT, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
